mem_bus_ctrl: RTL and testbench

//  Serialises the core's instruction-fetch and data load/store requests onto the single shared

---
 rtl/mem_bus_ctrl_pkg.sv | 16 +
 rtl/mem_bus_ctrl_timer.sv | 27 ++
 rtl/mem_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: word width, FSM encoding
// and the default transaction timeout.
package mem_bus_ctrl_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int TIMEOUT_DEF = 16;

  // 2-bit state encoding of the bus FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_DM_RD = 2'd2,
    ST_DM_WR = 2'd3
  } bus_state_e;

endpackage

// File: rtl/mem_bus_ctrl_timer.sv
// Transaction watchdog: counts cycles spent in a bus transaction and flags
// the last permitted cycle so the FSM can abort on the same edge.
module mem_bus_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt;

  // clear while idle, count while a transaction is outstanding, park at terminal
  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && !term)
      cnt <= cnt + 1'b1;
  end

  assign term = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Serialises instruction fetches and data loads/stores onto the single shared
// memory bus. Data requests win over fetches; a store wins over a load.
// All bus strobes and status outputs are registered.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  // fetch port
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 if_done,
  // data port
  input  logic                 dm_read,
  input  logic                 dm_write,
  input  logic [WORD_SIZE-1:0] dm_addr,
  input  logic [WORD_SIZE-1:0] dm_wdata,
  output logic [WORD_SIZE-1:0] dm_rdata,
  output logic                 dm_done,
  // status
  output logic                 busy,
  output logic                 bus_error,
  // memory bus
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput
);

  bus_state_e           state;
  logic [WORD_SIZE-1:0] wr_reg;
  logic                 tmo;

  mem_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_IDLE),
    .en    (state != ST_IDLE),
    .term  (tmo)
  );

  // bus is only driven while a store strobe is up
  assign data = writeM ? wr_reg : {WORD_SIZE{1'bz}};

  // bus FSM with registered strobes, done pulses and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      readM     <= 1'b0;
      writeM    <= 1'b0;
      address   <= '0;
      wr_reg    <= '0;
      instr     <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      busy      <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dm_write) begin
            state   <= ST_DM_WR;
            writeM  <= 1'b1;
            address <= dm_addr;
            wr_reg  <= dm_wdata;
            busy    <= 1'b1;
          end else if (dm_read) begin
            state   <= ST_DM_RD;
            readM   <= 1'b1;
            address <= dm_addr;
            busy    <= 1'b1;
          end else if (if_req) begin
            state   <= ST_IF_RD;
            readM   <= 1'b1;
            address <= if_addr;
            busy    <= 1'b1;
          end
        end
        ST_IF_RD: begin
          if (inputReady) begin
            instr   <= data;
            if_done <= 1'b1;
            readM   <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (tmo) begin
            readM     <= 1'b0;
            busy      <= 1'b0;
            bus_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_DM_RD: begin
          if (inputReady) begin
            dm_rdata <= data;
            dm_done  <= 1'b1;
            readM    <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (tmo) begin
            readM     <= 1'b0;
            busy      <= 1'b0;
            bus_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_DM_WR: begin
          if (ackOutput) begin
            dm_done <= 1'b1;
            writeM  <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (tmo) begin
            writeM    <= 1'b0;
            busy      <= 1'b0;
            bus_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (TIMEOUT=4). Inputs driven and outputs
// sampled on the falling edge; the memory side is driven by hand per test.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] instr;
  logic        if_done;
  logic        dm_read = 1'b0;
  logic        dm_write = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        busy;
  logic        bus_error;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        inputReady = 1'b0;
  logic        ackOutput = 1'b0;
  logic        mem_drive = 1'b0;
  logic [15:0] mem_data = '0;

  int n_vec = 0;
  int n_err = 0;

  assign data = mem_drive ? mem_data : 16'hzzzz;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .instr      (instr),
    .if_done    (if_done),
    .dm_read    (dm_read),
    .dm_write   (dm_write),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .busy       (busy),
    .bus_error  (bus_error),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady),
    .ackOutput  (ackOutput)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_vec++; if ({readM, writeM, busy, bus_error, if_done, dm_done} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 000000", {readM, writeM, busy, bus_error, if_done, dm_done}); end
    n_vec++; if (address !== 16'h0000) begin n_err++; $display("FAIL reset_addr got %h want 0000", address); end
    n_vec++; if (instr !== 16'h0000 || dm_rdata !== 16'h0000) begin
      n_err++; $display("FAIL reset_rdata got %h/%h want 0000/0000", instr, dm_rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int hi = 0;
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    n_vec++; if (readM !== 1'b1 || busy !== 1'b1 || address !== 16'h0010) begin
      n_err++; $display("FAIL fetch_start got readM=%b busy=%b addr=%h want 1 1 0010", readM, busy, address); end
    hi++;
    tick(); if (readM) hi++;
    tick(); if (readM) hi++;
    inputReady = 1'b1; mem_drive = 1'b1; mem_data = 16'hABCD;
    tick();
    n_vec++; if (hi !== 3) begin n_err++; $display("FAIL fetch_readM_cycles got %0d want 3", hi); end
    n_vec++; if (if_done !== 1'b1 || instr !== 16'hABCD) begin
      n_err++; $display("FAIL fetch_done got if_done=%b instr=%h want 1 abcd", if_done, instr); end
    n_vec++; if (readM !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL fetch_release got readM=%b busy=%b want 0 0", readM, busy); end
    if_req = 1'b0; inputReady = 1'b0; mem_drive = 1'b0;
    tick();
    n_vec++; if (if_done !== 1'b0 || readM !== 1'b0) begin
      n_err++; $display("FAIL fetch_pulse got if_done=%b readM=%b want 0 0", if_done, readM); end
  endtask

  task automatic test_store();
    dm_write = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    tick();
    n_vec++; if (writeM !== 1'b1 || readM !== 1'b0 || address !== 16'h0020) begin
      n_err++; $display("FAIL store_start got writeM=%b readM=%b addr=%h want 1 0 0020", writeM, readM, address); end
    n_vec++; if (data !== 16'h1234) begin n_err++; $display("FAIL store_data got %h want 1234", data); end
    dm_wdata = 16'hFFFF;
    tick();
    n_vec++; if (data !== 16'h1234 || dm_done !== 1'b0) begin
      n_err++; $display("FAIL store_hold got data=%h dm_done=%b want 1234 0", data, dm_done); end
    ackOutput = 1'b1;
    tick();
    n_vec++; if (dm_done !== 1'b1 || writeM !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL store_done got dm_done=%b writeM=%b busy=%b want 1 0 0", dm_done, writeM, busy); end
    dm_write = 1'b0; ackOutput = 1'b0; mem_drive = 1'b1; mem_data = 16'h0000;
    #1;
    n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL store_released got %h want 0000", data); end
    mem_drive = 1'b0;
    tick();
    n_vec++; if (dm_done !== 1'b0) begin n_err++; $display("FAIL store_pulse got %b want 0", dm_done); end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 16'h0030; dm_read = 1'b1; dm_addr = 16'h0040;
    tick();
    n_vec++; if (readM !== 1'b1 || address !== 16'h0040) begin
      n_err++; $display("FAIL prio_dm_first got readM=%b addr=%h want 1 0040", readM, address); end
    inputReady = 1'b1; mem_drive = 1'b1; mem_data = 16'h5555;
    tick();
    n_vec++; if (dm_done !== 1'b1 || dm_rdata !== 16'h5555 || if_done !== 1'b0 || readM !== 1'b0) begin
      n_err++; $display("FAIL prio_dm_done got dm_done=%b rdata=%h if_done=%b readM=%b want 1 5555 0 0",
                        dm_done, dm_rdata, if_done, readM); end
    dm_read = 1'b0; inputReady = 1'b0; mem_drive = 1'b0;
    tick();
    n_vec++; if (readM !== 1'b1 || address !== 16'h0030 || busy !== 1'b1) begin
      n_err++; $display("FAIL prio_fetch_next got readM=%b addr=%h busy=%b want 1 0030 1", readM, address, busy); end
    inputReady = 1'b1; mem_drive = 1'b1; mem_data = 16'h7777;
    tick();
    n_vec++; if (if_done !== 1'b1 || instr !== 16'h7777 || dm_done !== 1'b0) begin
      n_err++; $display("FAIL prio_fetch_done got if_done=%b instr=%h dm_done=%b want 1 7777 0", if_done, instr, dm_done); end
    if_req = 1'b0; inputReady = 1'b0; mem_drive = 1'b0;
    tick();
    // load and store together: the store alone is performed
    dm_read = 1'b1; dm_write = 1'b1; dm_addr = 16'h0044; dm_wdata = 16'h0BAD;
    tick();
    n_vec++; if (writeM !== 1'b1 || readM !== 1'b0 || data !== 16'h0BAD) begin
      n_err++; $display("FAIL prio_store_over_load got writeM=%b readM=%b data=%h want 1 0 0bad", writeM, readM, data); end
    ackOutput = 1'b1;
    tick();
    dm_read = 1'b0; dm_write = 1'b0; ackOutput = 1'b0;
    tick();
    n_vec++; if (readM !== 1'b0 || writeM !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL prio_store_only got readM=%b writeM=%b busy=%b want 0 0 0", readM, writeM, busy); end
  endtask

  task automatic test_stray();
    inputReady = 1'b1; ackOutput = 1'b1;
    tick();
    n_vec++; if ({busy, readM, writeM, if_done, dm_done} !== 5'b0) begin
      n_err++; $display("FAIL stray_idle got %b want 00000", {busy, readM, writeM, if_done, dm_done}); end
    inputReady = 1'b0;
    if_req = 1'b1; if_addr = 16'h0060;
    tick();
    tick();
    n_vec++; if (if_done !== 1'b0 || readM !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL stray_ack_in_rd got if_done=%b readM=%b busy=%b want 0 1 1", if_done, readM, busy); end
    ackOutput = 1'b0; inputReady = 1'b1; mem_drive = 1'b1; mem_data = 16'h0F0F;
    tick();
    n_vec++; if (if_done !== 1'b1 || instr !== 16'h0F0F) begin
      n_err++; $display("FAIL stray_recover got if_done=%b instr=%h want 1 0f0f", if_done, instr); end
    if_req = 1'b0; inputReady = 1'b0; mem_drive = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit seen_done = 1'b0;
    bit ended = 1'b0;
    if_req = 1'b1; if_addr = 16'h0050;
    for (int i = 0; i < 20 && !ended; i++) begin
      tick();
      if (if_done) seen_done = 1'b1;
      if (readM) hi++;
      else begin ended = 1'b1; if_req = 1'b0; end
    end
    n_vec++; if (!ended) begin n_err++; $display("FAIL timeout_expired got readM=1 after 20 cycles want 0"); end
    n_vec++; if (hi !== 4) begin n_err++; $display("FAIL timeout_cycles got %0d want 4", hi); end
    n_vec++; if (bus_error !== 1'b1 || busy !== 1'b0 || seen_done) begin
      n_err++; $display("FAIL timeout_abort got err=%b busy=%b done_seen=%b want 1 0 0", bus_error, busy, seen_done); end
    tick();
    dm_read = 1'b1; dm_addr = 16'h0058;
    tick();
    inputReady = 1'b1; mem_drive = 1'b1; mem_data = 16'h2222;
    tick();
    dm_read = 1'b0; inputReady = 1'b0; mem_drive = 1'b0;
    n_vec++; if (bus_error !== 1'b1 || dm_done !== 1'b1 || dm_rdata !== 16'h2222) begin
      n_err++; $display("FAIL timeout_sticky got err=%b dm_done=%b rdata=%h want 1 1 2222", bus_error, dm_done, dm_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    dm_write = 1'b1; dm_addr = 16'h0070; dm_wdata = 16'hBEEF;
    tick();
    n_vec++; if (writeM !== 1'b1 || data !== 16'hBEEF) begin
      n_err++; $display("FAIL rstwr_start got writeM=%b data=%h want 1 beef", writeM, data); end
    reset = 1'b1; dm_write = 1'b0;
    tick();
    n_vec++; if (writeM !== 1'b0 || busy !== 1'b0 || dm_done !== 1'b0 || bus_error !== 1'b0) begin
      n_err++; $display("FAIL rstwr_abort got writeM=%b busy=%b dm_done=%b err=%b want 0 0 0 0", writeM, busy, dm_done, bus_error); end
    mem_drive = 1'b1; mem_data = 16'h0000;
    #1;
    n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL rstwr_released got %h want 0000", data); end
    mem_drive = 1'b0; reset = 1'b0;
    tick();
    n_vec++; if (dm_done !== 1'b0 || writeM !== 1'b0) begin
      n_err++; $display("FAIL rstwr_no_done got dm_done=%b writeM=%b want 0 0", dm_done, writeM); end
  endtask

  // readM and writeM must never be up together
  always @(negedge clk) begin
    if (!reset && readM && writeM) begin
      n_err++; $display("FAIL strobe_exclusive got readM=1 writeM=1 want not both");
    end
  end

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_stray();
    test_timeout();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
